// File: rtl/jk_reg_bank_pkg.sv
// Shared types for the JK register bank: operating modes and the per-cell
// action encoding, which is simply the {j,k} pair.
package jk_pkg;

    typedef enum logic [1:0] {
        MODE_JK   = 2'b00,
        MODE_UP   = 2'b01,
        MODE_DOWN = 2'b10,
        MODE_LOAD = 2'b11
    } jk_mode_e;

    typedef enum logic [1:0] {
        HOLD = 2'b00,
        CLR  = 2'b01,
        SET  = 2'b10,
        TGL  = 2'b11
    } jk_act_e;

endpackage

// File: rtl/jk_reg_bank_if.sv
// Control/data bundle of the JK register bank. There is no handshake: the
// bank samples en/mode/j/k on every rising clock edge.
interface jk_reg_bank_if
    import jk_pkg::*;
#(
    parameter int WIDTH = 8
) ();

    logic             en;
    jk_mode_e         mode;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qbar;
    logic             tc;

    modport master (output en, mode, j, k, input q, qbar, tc);
    modport slave  (input en, mode, j, k, output q, qbar, tc);

endinterface

// File: rtl/jk_reg_bank_cell.sv
// One JK master cell: synchronous active-low reset to its own reset bit,
// otherwise hold/clear/set/toggle when enabled.
module jk_cell
    import jk_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic jx_i,
    input  logic kx_i,
    input  logic rst_val_i,
    output logic m_o
);

    logic m_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            m_q <= rst_val_i;
        end else if (en_i) begin
            case (jk_act_e'({jx_i, kx_i}))
                HOLD: m_q <= m_q;
                CLR:  m_q <= 1'b0;
                SET:  m_q <= 1'b1;
                TGL:  m_q <= ~m_q;
            endcase
        end
    end

    assign m_o = m_q;

endmodule

// File: rtl/jk_reg_bank.sv
// WIDTH-bit bank of JK cells usable as a plain JK register, up/down counter
// or parallel-load register, with an optional master-slave output stage.
module jk_reg_bank
    import jk_pkg::*;
#(
    parameter int               WIDTH        = 8,
    parameter bit               MASTER_SLAVE = 1'b1,
    parameter logic [WIDTH-1:0] RESET_VAL    = '0
) (
    input logic          clk,
    input logic          reset,
    jk_reg_bank_if.slave bus
);

    logic [WIDTH-1:0] master_q;
    logic [WIDTH-1:0] tgl_up;
    logic [WIDTH-1:0] tgl_dn;
    logic [WIDTH-1:0] jx;
    logic [WIDTH-1:0] kx;

    // Toggle cascades look only at master so the slave stage never double-counts.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        if (i == 0) begin : g_lsb
            assign tgl_up[i] = 1'b1;
            assign tgl_dn[i] = 1'b1;
        end else begin : g_upper
            assign tgl_up[i] = &master_q[i-1:0];
            assign tgl_dn[i] = ~|master_q[i-1:0];
        end

        jk_cell u_cell (
            .clk       (clk),
            .reset     (reset),
            .en_i      (bus.en),
            .jx_i      (jx[i]),
            .kx_i      (kx[i]),
            .rst_val_i (RESET_VAL[i]),
            .m_o       (master_q[i])
        );
    end

    always_comb begin
        jx = bus.j;
        kx = bus.k;
        case (bus.mode)
            MODE_JK: begin
                jx = bus.j;
                kx = bus.k;
            end
            MODE_UP: begin
                jx = tgl_up;
                kx = tgl_up;
            end
            MODE_DOWN: begin
                jx = tgl_dn;
                kx = tgl_dn;
            end
            MODE_LOAD: begin
                jx = bus.j;
                kx = ~bus.j;
            end
        endcase
    end

    if (MASTER_SLAVE) begin : g_slave
        logic [WIDTH-1:0] slave_q;

        // The slave copies master every edge, so held updates still reach q.
        always_ff @(posedge clk) begin
            if (!reset) begin
                slave_q <= RESET_VAL;
            end else begin
                slave_q <= master_q;
            end
        end

        assign bus.q = slave_q;
    end else begin : g_direct
        assign bus.q = master_q;
    end

    assign bus.qbar = ~bus.q;
    assign bus.tc   = ((bus.mode == MODE_UP)   && (&bus.q)) ||
                      ((bus.mode == MODE_DOWN) && (~|bus.q));

endmodule
